// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler feeding the 16-point FFT core: fills one bank from a
// valid/ready sample stream while the core works on the other bank.
module fft_frame_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_real,
    input  logic [DATA_WIDTH-1:0] s_imag,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] real_out [0:N-1],
    output logic [DATA_WIDTH-1:0] imag_out [0:N-1],
    output logic                  start_fft,
    input  logic                  fft_done,
    output logic [15:0]           frame_count
);

    localparam int unsigned IdxW = $clog2(N);

    typedef enum logic [1:0] {BankEmpty, BankFull, BankBusy} bank_status_e;
    typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

    logic [DATA_WIDTH-1:0] mem_real [2][N];
    logic [DATA_WIDTH-1:0] mem_imag [2][N];
    bank_status_e          status   [2];

    state_e            state;
    logic              wr_bank;
    logic              rd_bank;
    logic [IdxW-1:0]   wr_idx;
    logic              wr_fire;
    logic              wr_last;

    assign s_ready = (status[wr_bank] == BankEmpty) && !flush;
    assign wr_fire = s_valid && s_ready;
    assign wr_last = wr_fire && (wr_idx == IdxW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_real[b][i] <= '0;
                    mem_imag[b][i] <= '0;
                end
            end
        end else if (wr_fire) begin
            mem_real[wr_bank][wr_idx] <= s_real;
            mem_imag[wr_bank][wr_idx] <= s_imag;
        end
    end

    // Write-side and FSM status updates always target different banks: the
    // write bank is never the bank held FULL/BUSY by the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            status[0]   <= BankEmpty;
            status[1]   <= BankEmpty;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_idx      <= '0;
            start_fft   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            if (flush) begin
                wr_idx <= '0;
            end else if (wr_fire) begin
                wr_idx <= wr_idx + IdxW'(1);
                if (wr_last) begin
                    status[wr_bank] <= BankFull;
                    wr_bank         <= ~wr_bank;
                end
            end

            unique case (state)
                StIdle: begin
                    if (status[rd_bank] == BankFull) begin
                        state     <= StStart;
                        start_fft <= 1'b1;
                    end
                end
                StStart: begin
                    start_fft       <= 1'b0;
                    status[rd_bank] <= BankBusy;
                    frame_count     <= frame_count + 16'd1;
                    state           <= StWaitDone;
                end
                StWaitDone: begin
                    if (fft_done) begin
                        status[rd_bank] <= BankEmpty;
                        rd_bank         <= ~rd_bank;
                        state           <= StIdle;
                    end
                end
                default: begin
                    start_fft <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            real_out[i] = mem_real[rd_bank][i];
            imag_out[i] = mem_imag[rd_bank][i];
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: accepted samples build expected frames
// that are popped and compared against the presented bank on each start_fft.
module tb_fft_frame_loader;

    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_imag;
    logic          flush;
    logic [DW-1:0] real_out [0:N-1];
    logic [DW-1:0] imag_out [0:N-1];
    logic          start_fft;
    logic          fft_done;
    logic [15:0]   frame_count;

    fft_frame_loader #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_imag      (s_imag),
        .flush       (flush),
        .real_out    (real_out),
        .imag_out    (imag_out),
        .start_fft   (start_fft),
        .fft_done    (fft_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [N*DW-1:0] exp_re_q [$];
    logic [N*DW-1:0] exp_im_q [$];
    logic [N*DW-1:0] fill_re, fill_im, cur_re, cur_im;
    int   fill_n, cyc, n_acc, n_start, n_stall, exp_fc;
    int   last_full_cyc, last_start_cyc, last_done_cyc, done_cnt, done_delay;
    logic busy, prev_start, pending_fc, acc_flag, auto_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_re_q.delete();
        exp_im_q.delete();
        fill_n     = 0;
        busy       = 1'b0;
        prev_start = 1'b0;
        pending_fc = 1'b0;
        done_cnt   = 0;
        exp_fc     = 0;
    endtask

    // Observation point, half a cycle away from the active edge.
    task automatic monitor();
        cyc++;
        acc_flag = 1'b0;
        if (pending_fc) begin
            check("frame_count", 32'(frame_count), 32'(16'(exp_fc)));
            pending_fc = 1'b0;
        end
        if (busy && !start_fft) begin
            check("hold_re7", 32'(real_out[7]), 32'(cur_re[7*DW +: DW]));
            check("hold_im15", 32'(imag_out[15]), 32'(cur_im[15*DW +: DW]));
        end
        if (start_fft) begin
            check("start_gap", 32'(prev_start || busy), 0);
            check("sb_nonempty", 32'(exp_re_q.size() != 0), 1);
            if (exp_re_q.size() != 0) begin
                cur_re = exp_re_q.pop_front();
                cur_im = exp_im_q.pop_front();
                for (int k = 0; k < N; k++) begin
                    check("frame_re", 32'(real_out[k]), 32'(cur_re[k*DW +: DW]));
                    check("frame_im", 32'(imag_out[k]), 32'(cur_im[k*DW +: DW]));
                end
            end
            busy           = 1'b1;
            n_start++;
            last_start_cyc = cyc;
            exp_fc++;
            pending_fc     = 1'b1;
        end else if (fft_done && busy) begin
            busy          = 1'b0;
            last_done_cyc = cyc;
        end
        if (flush) begin
            fill_n = 0;
        end else if (s_valid && s_ready) begin
            fill_re[fill_n*DW +: DW] = s_real;
            fill_im[fill_n*DW +: DW] = s_imag;
            fill_n++;
            n_acc++;
            acc_flag = 1'b1;
            if (fill_n == N) begin
                exp_re_q.push_back(fill_re);
                exp_im_q.push_back(fill_im);
                last_full_cyc = cyc;
                fill_n        = 0;
            end
        end
        if (s_valid && !s_ready) n_stall++;
        prev_start = start_fft;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) fft_done = 1'b1;
        end
        if (start_fft && auto_done) done_cnt = done_delay;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s_valid  = 1'b0;
        flush    = 1'b0;
        fft_done = 1'b0;
        #2;
        check("rst_start", 32'(start_fft), 0);
        check("rst_fc", 32'(frame_count), 0);
        check("rst_re0", 32'(real_out[0]), 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(s_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int n = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 200);
        if (!acc_flag) check("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (n_start < target && n < 60) begin
            tick();
            n++;
        end
        check("start_seen", n_start, target);
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick();
    endtask

    int base_acc, base_start, base_stall;
    logic [15:0] fc_before;

    initial begin
        cyc = 0; n_acc = 0; n_start = 0; n_stall = 0;
        last_full_cyc = 0; last_start_cyc = 0; last_done_cyc = 0;
        auto_done = 1'b0; done_delay = 3; s_real = '0; s_imag = '0;
        fill_re = '0; fill_im = '0; cur_re = '0; cur_im = '0;
        do_reset();

        // Reset mid-frame, then a clean single frame real=i, imag=-i
        for (int i = 0; i < 5; i++) send(16'(16'h1111 + i), 16'(16'h2222 + i));
        do_reset();
        base_start = n_start;
        for (int i = 0; i < N; i++) send(16'(i), 16'(-i));
        wait_start(base_start + 1);
        check("start_latency", last_start_cyc - last_full_cyc, 2);
        repeat (5) tick();
        check("single_starts", n_start - base_start, 1);
        check("single_re7", 32'(real_out[7]), 32'(16'd7));
        check("single_im15", 32'(imag_out[15]), 32'(16'hFFF1));
        check("single_fc", 32'(frame_count), 1);
        pulse_done();

        // Ping-pong with a fast core
        do_reset();
        auto_done  = 1'b1;
        base_start = n_start;
        base_stall = n_stall;
        for (int i = 0; i < 3 * N; i++) send(16'(16'h0100 + i * 3), 16'(16'h7000 - i));
        wait_start(base_start + 3);
        repeat (8) tick();
        check("pp_starts", n_start - base_start, 3);
        check("pp_stalls", n_stall - base_stall, 0);
        check("pp_fc", 32'(frame_count), 3);
        auto_done = 1'b0;

        // Backpressure with the core holding its frame
        do_reset();
        base_start = n_start;
        for (int i = 0; i < 2 * N; i++) send(16'(16'h0200 + i), 16'(16'h0A00 + i));
        check("bp_ready_low", 32'(s_ready), 0);
        base_acc = n_acc;
        s_valid  = 1'b1;
        s_real   = 16'h0220;
        s_imag   = 16'h0A20;
        repeat (8) tick();
        check("bp_no_accept", n_acc - base_acc, 0);
        check("bp_one_start", n_start - base_start, 1);
        pulse_done();
        for (int i = 2 * N; i < 40; i++) send(16'(16'h0200 + i), 16'(16'h0A00 + i));
        check("bp_resume", n_acc - base_acc, 8);
        wait_start(base_start + 2);
        check("bp_restart_lat", last_start_cyc - last_done_cyc, 2);
        pulse_done();

        // Flush discards a partial bank
        do_reset();
        base_start = n_start;
        for (int i = 0; i < 6; i++) send(16'(16'h0300 + i), 16'(16'h0300 + i));
        s_valid = 1'b1;
        s_real  = 16'hDEAD;
        s_imag  = 16'hBEEF;
        flush   = 1'b1;
        #1;
        check("flush_ready", 32'(s_ready), 0);
        base_acc = n_acc;
        tick();
        check("flush_no_accept", n_acc - base_acc, 0);
        flush   = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < N; i++) send(16'h0100, 16'h0100);
        wait_start(base_start + 1);
        pulse_done();

        // Spurious done in idle, then done coinciding with the last accept
        fc_before  = frame_count;
        base_start = n_start;
        pulse_done();
        tick();
        check("spur_ready", 32'(s_ready), 1);
        check("spur_fc", 32'(frame_count), 32'(fc_before));
        check("spur_no_start", n_start - base_start, 0);
        for (int i = 0; i < N; i++) send(16'(16'h0400 + i), 16'(16'h0800 - i));
        wait_start(base_start + 1);
        for (int i = 0; i < N - 1; i++) send(16'(16'h0500 + i), 16'(16'h0900 + i));
        s_valid  = 1'b1;
        s_real   = 16'h050F;
        s_imag   = 16'h090F;
        fft_done = 1'b1;
        tick();
        check("sim_accept", 32'(acc_flag), 1);
        s_valid = 1'b0;
        check("sim_coincide", last_full_cyc - last_done_cyc, 0);
        wait_start(base_start + 2);
        check("sim_start_lat", last_start_cyc - last_done_cyc, 2);
        pulse_done();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
